// File: rtl/sha256_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_sched (with sha256_s0 / sha256_s1 helpers)
// Description : SHA-256 message schedule producer. Takes 16 message words
//               and streams W0..W63 with round index over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================

module sha256_s0 (
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);
    assign o_y = {i_x[6:0], i_x[31:7]} ^ {i_x[17:0], i_x[31:18]} ^ (i_x >> 3);
endmodule

module sha256_s1 (
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);
    assign o_y = {i_x[16:0], i_x[31:17]} ^ {i_x[18:0], i_x[31:19]} ^ (i_x >> 10);
endmodule

module sha256_msg_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_word,
    output logic [5:0]  w_round,
    output logic        w_last,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_LOAD   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [31:0] r_win [16];
    logic        r_valid;
    logic        r_last;
    logic        r_busy;
    logic [31:0] r_word;
    logic [5:0]  r_round;

    logic        w_free;
    logic        w_load;
    logic        w_accept;
    logic [31:0] w_s0;
    logic [31:0] w_s1;
    logic [31:0] w_expand;
    logic [31:0] w_new;

    // win[0] = W(t-16), win[1] = W(t-15), win[9] = W(t-7), win[14] = W(t-2)
    sha256_s0 u_s0 (.i_x(r_win[1]),  .o_y(w_s0));
    sha256_s1 u_s1 (.i_x(r_win[14]), .o_y(w_s1));

    assign w_expand = w_s1 + r_win[9] + w_s0 + r_win[0];
    assign w_free   = !r_valid || w_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_new       = in_word;
        in_ready    = 1'b0;
        case (r_state)
            ST_LOAD: begin
                in_ready = w_free;
                if (in_valid && w_free) begin
                    w_load    = 1'b1;
                    w_cnt_nxt = r_cnt + 6'd1;
                    if (r_cnt == 6'd15)
                        w_state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_new = w_expand;
                if (w_free) begin
                    w_load = 1'b1;
                    if (r_cnt == 6'd63) begin
                        w_cnt_nxt   = 6'd0;
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_cnt   <= 6'd0;
            r_valid <= 1'b0;
            r_word  <= 32'd0;
            r_round <= 6'd0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_valid <= 1'b1;
                r_word  <= w_new;
                r_round <= r_cnt;
                r_last  <= (r_cnt == 6'd63);
            end else if (w_ready) begin
                r_valid <= 1'b0;
            end
            // Set wins so a back-to-back M0 on the W63 handoff edge keeps busy high
            if (w_accept && r_cnt == 6'd0)
                r_busy <= 1'b1;
            else if (r_valid && w_ready && r_last)
                r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++)
                r_win[i] <= 32'd0;
        end else if (w_load) begin
            for (int i = 0; i < 15; i++)
                r_win[i] <= r_win[i+1];
            r_win[15] <= w_new;
        end
    end

    assign w_valid = r_valid;
    assign w_word  = r_word;
    assign w_round = r_round;
    assign w_last  = r_last;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_msg_sched
// Description : Directed bench for sha256_msg_sched with schedule reference.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_sha256_msg_sched;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_word;
    logic [5:0]  w_round;
    logic        w_last;
    logic        busy;

    sha256_msg_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_word   (w_word),
        .w_round  (w_round),
        .w_last   (w_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    logic [31:0] msg  [2][16];
    logic [31:0] expw [2][64];
    logic [31:0] got_w [128];
    int          got_r [128];
    logic        got_l [128];
    int          hand_cyc [128];
    int          acc_cyc  [32];

    int n_acc, n_hand, cycles, gap_left;
    int ir_err, busy_err, last_err, stab_err, b2b_err;
    bit aborted;

    task automatic build_exp(input int b);
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = msg[b][t];
        for (int t = 16; t < 64; t++)
            w[t] = ms1(w[t-2]) + w[t-7] + ms0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) expw[b][t] = w[t];
    endtask

    task automatic set_abc(input int b);
        for (int t = 0; t < 16; t++) msg[b][t] = 32'd0;
        msg[b][0]  = 32'h61626380;
        msg[b][15] = 32'h00000018;
        build_exp(b);
    endtask

    task automatic set_ones(input int b);
        for (int t = 0; t < 16; t++) msg[b][t] = 32'hFFFFFFFF;
        build_exp(b);
    endtask

    // Drive nb blocks; sample each cycle 1 time unit after the falling edge.
    task automatic run_blocks(input int nb, input bit rnd_ready, input bit gaps, input int abort_at);
        bit          prev_stall;
        logic [31:0] prev_word;
        logic [5:0]  prev_round;
        logic        prev_last;
        bit          handoff;
        bit          exp_ir;
        n_acc = 0; n_hand = 0; cycles = 0; gap_left = 0;
        ir_err = 0; busy_err = 0; last_err = 0; stab_err = 0; b2b_err = 0;
        aborted = 1'b0; prev_stall = 1'b0;
        prev_word = '0; prev_round = '0; prev_last = 1'b0;
        while (n_hand < 64 * nb && cycles < 4000) begin
            @(negedge clk);
            if (prev_stall && (!w_valid || w_word !== prev_word ||
                               w_round !== prev_round || w_last !== prev_last))
                stab_err++;
            w_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (gap_left > 0) begin
                in_valid = 1'b0;
                gap_left--;
            end else if (n_acc < 16 * nb) begin
                in_valid = 1'b1;
                in_word  = msg[n_acc / 16][n_acc % 16];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (abort_at >= 0 && w_valid && int'(w_round) == abort_at) begin
                aborted = 1'b1;
                break;
            end
            exp_ir = (((n_hand + int'(w_valid)) % 64) < 16) && (!w_valid || w_ready);
            if (in_ready !== exp_ir) ir_err++;
            if (busy !== (n_hand < 4 * n_acc)) busy_err++;
            if (w_valid && (w_last !== (w_round == 6'd63))) last_err++;
            handoff = w_valid && w_ready;
            if (handoff) begin
                got_w[n_hand]    = w_word;
                got_r[n_hand]    = int'(w_round);
                got_l[n_hand]    = w_last;
                hand_cyc[n_hand] = cycles;
            end
            if (in_valid && in_ready) begin
                if (n_acc == 16 && !(handoff && w_last)) b2b_err++;
                acc_cyc[n_acc] = cycles;
                n_acc++;
                gap_left = gaps ? $urandom_range(1, 5) : 0;
            end
            if (handoff) n_hand++;
            prev_stall = w_valid && !w_ready;
            prev_word  = w_word;
            prev_round = w_round;
            prev_last  = w_last;
            cycles++;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_run(input string name, input int nb);
        int seq_w, seq_r, nlast, lidx;
        seq_w = 0; seq_r = 0; nlast = 0; lidx = -1;
        check({name, "_handoffs"}, n_hand, 64 * nb);
        for (int i = 0; i < n_hand && i < 64 * nb; i++) begin
            if (got_w[i] !== expw[i / 64][i % 64]) seq_w++;
            if (got_r[i] != i % 64) seq_r++;
            if (got_l[i]) begin nlast++; lidx = i; end
        end
        check({name, "_word_errs"},  seq_w, 0);
        check({name, "_round_errs"}, seq_r, 0);
        check({name, "_last_count"}, nlast, nb);
        check({name, "_last_idx"},   lidx, 64 * nb - 1);
        check({name, "_in_ready_errs"}, ir_err, 0);
        check({name, "_busy_errs"},  busy_err, 0);
        check({name, "_last_flag_errs"}, last_err, 0);
        check({name, "_stall_errs"}, stab_err, 0);
    endtask

    task automatic do_reset;
        in_valid = 1'b0;
        in_word  = '0;
        w_ready  = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        do_reset();
        #1;
        check("rst_w_valid",  w_valid, 0);
        check("rst_w_word",   w_word,  0);
        check("rst_w_round",  w_round, 0);
        check("rst_w_last",   w_last,  0);
        check("rst_busy",     busy,    0);
        check("rst_in_ready", in_ready, 1);

        // "abc" block, consumer always ready
        set_abc(0);
        run_blocks(1, 1'b0, 1'b0, -1);
        check_run("abc", 1);
        check("abc_W16", got_w[16], 32'h61626380);
        check("abc_W17", got_w[17], 32'h000F0000);
        check("abc_W18", got_w[18], 32'h7DA86405);
        check("abc_W19", got_w[19], 32'h600003C6);
        check("abc_W0",  got_w[0],  32'h61626380);
        check("abc_W15", got_w[15], 32'h00000018);
        check("abc_latency", hand_cyc[0] - acc_cyc[0], 1);

        // same block, random back-pressure
        run_blocks(1, 1'b1, 1'b0, -1);
        check_run("abc_bp", 1);

        // two blocks back to back, in_valid held high
        set_ones(1);
        run_blocks(2, 1'b0, 1'b0, -1);
        check_run("b2b", 2);
        check("b2b_m0_on_w63", b2b_err, 0);
        check("b2b_blk2_W16", got_w[64 + 16], 32'h203FFFFC);

        // input gaps during LOAD
        set_abc(0);
        run_blocks(1, 1'b0, 1'b1, -1);
        check_run("gaps", 1);

        // asynchronous reset mid-block at round 30
        run_blocks(1, 1'b0, 1'b0, 30);
        check("abort_reached", aborted, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_w_valid", w_valid, 0);
        check("mid_rst_w_word",  w_word,  0);
        check("mid_rst_w_round", w_round, 0);
        check("mid_rst_w_last",  w_last,  0);
        check("mid_rst_busy",    busy,    0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        run_blocks(1, 1'b0, 1'b0, -1);
        check_run("post_rst", 1);
        check("post_rst_W18", got_w[18], 32'h7DA86405);

        // all-ones block: modular wrap of the four-term sum
        set_ones(0);
        run_blocks(1, 1'b1, 1'b1, -1);
        check_run("ones", 1);
        check("ones_W16", got_w[16], 32'h203FFFFC);
        check("ones_W17", got_w[17], 32'h203FFFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
